branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//   Tracks in-flight branch predictions from IF until EX resolves them, in program order.
//   On resolution it compares the actual outcome with the recorded prediction.
//   It drives the update side of the 2-bit counter table (counter_update / actual_taken / index).
//   It also drives the pipeline mispredict flush and the redirect PC.
// PARAMETERS
//   DEPTH     4   max in-flight predicted control instrs (power of 2, >=2)
//   XLEN      32  PC / target width
//   GHR_BITS  5   global-history width; also the counter-table index width
// PORTS
//   clk            in   1         clock
//   reset          in   1         synchronous, active-high
//   pred_valid     in   1         IF pushes a predicted control instr this cycle
//   pred_pc        in   XLEN      PC of that instr
//   pred_taken     in   1         predicted direction
//   pred_target    in   XLEN      predicted target (don't-care if not taken)
//   pred_ghr       in   GHR_BITS  history snapshot used for the lookup
//   pred_ready     out  1         queue not full; IF stalls when 0
//   res_valid      in   1         EX resolves the oldest in-flight control instr
//   res_taken      in   1         actual direction
//   res_target     in   XLEN      actual target
//   upd_valid      out  1         counter_update to the counter table (registered)
//   upd_taken      out  1         actual_taken to the counter table (registered)
//   upd_index      out  GHR_BITS  table index = pc[GHR_BITS+1:2] ^ ghr (registered)
//   mispredict     out  1         flush request (combinational)
//   redirect_pc    out  XLEN      correct next PC; valid when mispredict=1
//   occupancy      out  $clog2(DEPTH+1)  entries held
//   err_underflow  out  1         sticky: res_valid arrived while the queue was empty
// BEHAVIOUR
//   Reset: queue empty and all pointers 0; upd_valid/upd_taken/upd_index=0; err_underflow=0.
//   Reset: mispredict=0; pred_ready=1; occupancy=0. Reset mid-operation discards all entries.
//   Storage: circular FIFO; each entry holds {pc, taken, target, ghr}.
//   Push: pred_valid && pred_ready. pred_ready = (occupancy != DEPTH); no bypass when full.
//   Pop: res_valid && occupancy!=0. The head entry is compared in the same cycle.
//   mispredict = pop && ((res_taken != head.taken) || (res_taken && res_target != head.target)).
//   redirect_pc = res_taken ? res_target : head.pc + 4; the adder wraps modulo 2^XLEN.
//   A wrong target with the correct direction counts as a mispredict.
//   A wrong target with the correct direction still updates the counter as taken.
//   Counter update: every pop registers upd_valid=1, upd_taken=res_taken, upd_index from the head.
//   The update appears exactly 1 cycle after the pop; otherwise upd_valid=0 (single-cycle pulse).
//   Mispredict edge: the queue is fully cleared (all younger entries are wrong-path).
//   Mispredict edge: a push in the same cycle is dropped. occupancy=0 next cycle.
//   Push+pop, no mispredict: occupancy unchanged; both pointers advance.
//   res_valid with an empty queue: ignored. No update pulse, no mispredict. err_underflow<=1.
//   err_underflow clears only on reset.
//   Pointers: log2(DEPTH) bits plus a wrap bit; full/empty are decided by the wrap bit.
// CONFIGURATION
//   BRQ_STATS_EN defined: adds ports stat_branches and stat_mispredicts (out, 32 each).
//     stat_branches: saturating count of pops. stat_mispredicts: saturating count of mispredicts.
//     Both counters stop at 32'hFFFF_FFFF and reset to 0.
//   BRQ_STATS_EN undefined: neither the ports nor the counters exist; behaviour is otherwise identical.
// STRUCTURE
//   Shared package bpred_pkg:
//     brq_entry_t struct {pc, taken, target, ghr}
//     index-hash function used by both the lookup side and this block
//     PC_STEP=4 constant
//   Sub-module bpred_fifo: generic DEPTH-entry FIFO with push/pop/clear, full, empty and count.
//   This block adds the compare, update-register and stats logic around bpred_fifo.
// TESTING
//   1. Push pc=0x100, taken=1, tgt=0x200, ghr=0. Resolve taken, 0x200.
//      -> mispredict=0. Next cycle upd_valid=1, upd_taken=1, upd_index=0x00.
//   2. Push pc=0x104, taken=0, ghr=5'h03. Resolve taken, 0x300.
//      -> mispredict=1, redirect=0x300. upd_index=0x01^0x03=0x02, upd_taken=1.
//   3. Push 3 entries; the first mispredicts (pred taken, actual not-taken, pc=0x80).
//      -> redirect=0x84. occupancy=0 next cycle; the same-cycle push is dropped.
//   4. Fill 4 entries -> pred_ready=0 and a further push is ignored.
//      Push+pop in the same cycle while at 3 -> occupancy stays 3.
//   5. res_valid on an empty queue -> no upd_valid, no mispredict, err_underflow=1.
//      err_underflow stays 1 until reset.
//   6. Assert reset with 2 entries queued and an update pending.
//      -> next cycle occupancy=0, upd_valid=0, pred_ready=1.
//      With BRQ_STATS_EN defined, both stats counters read 0.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared branch-predictor entry type, counter-table index hash and PC step
package bpred_pkg;
  localparam int BP_XLEN = 32;
  localparam int BP_GHR_BITS = 5;
  localparam logic [BP_XLEN-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [BP_XLEN-1:0]     pc;
    logic                   taken;
    logic [BP_XLEN-1:0]     target;
    logic [BP_GHR_BITS-1:0] ghr;
  } brq_entry_t;
  function automatic logic [BP_GHR_BITS-1:0] bp_index(input logic [BP_XLEN-1:0] pc, input logic [BP_GHR_BITS-1:0] ghr);
    return pc[BP_GHR_BITS+1:2] ^ ghr;
  endfunction
endpackage

// File: rtl/bpred_fifo.sv
// bpred_fifo: generic circular FIFO with push/pop/clear; wrap-bit pointers decide full/empty
module bpred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order branch resolution, counter-table update and mispredict redirect.
// Optional BRQ_STATS_EN adds saturating stat_branches / stat_mispredicts counters.
module branch_resolve_queue
  import bpred_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = BP_XLEN,
  parameter int GHR_BITS = BP_GHR_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [XLEN-1:0]            pred_pc,
  input  logic                       pred_taken,
  input  logic [XLEN-1:0]            pred_target,
  input  logic [GHR_BITS-1:0]        pred_ghr,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [XLEN-1:0]            res_target,
  output logic                       upd_valid,
  output logic                       upd_taken,
  output logic [GHR_BITS-1:0]        upd_index,
  output logic                       mispredict,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_underflow
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]                stat_branches,
  output logic [31:0]                stat_mispredicts
`endif
);
  brq_entry_t head, new_entry;
  logic full, empty, pop;
  assign new_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target, ghr: pred_ghr};
  bpred_fifo #(.DEPTH(DEPTH), .WIDTH($bits(brq_entry_t))) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(pred_valid && pred_ready),
    .pop(pop),
    .clear(mispredict),
    .din(new_entry),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(occupancy)
  );
  assign pred_ready = !full;
  assign pop = res_valid && !empty;
  // a correct direction with a wrong target still needs a redirect
  assign mispredict = pop && ((res_taken != head.taken) || (res_taken && res_target != head.target));
  assign redirect_pc = res_taken ? res_target : head.pc + PC_STEP;
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid <= 1'b0;
      upd_taken <= 1'b0;
      upd_index <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid <= pop;
      if (pop) begin
        upd_taken <= res_taken;
        upd_index <= bp_index(head.pc, head.ghr);
      end
      if (res_valid && empty) err_underflow <= 1'b1;
    end
  end
`ifdef BRQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed + randomized checks against a queue-based reference model
module tb_branch_resolve_queue;
  logic clk = 0, reset = 1;
  logic pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
  logic [31:0] pred_pc = 0, pred_target = 0, res_target = 0;
  logic [4:0] pred_ghr = 0;
  logic pred_ready, upd_valid, upd_taken, mispredict, err_underflow;
  logic [4:0] upd_index;
  logic [31:0] redirect_pc;
  logic [2:0] occupancy;
  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [4:0]  ghr;
  } ent_t;
  ent_t mq[$];
  logic m_upd_valid = 0, m_upd_taken = 0, m_err = 0;
  logic [4:0] m_upd_index = 0;

  branch_resolve_queue dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ghr(pred_ghr), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_index(upd_index),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit pv, input logic [31:0] pc, input bit pt,
                       input logic [31:0] ptgt, input logic [4:0] pg,
                       input bit rv, input bit rt, input logic [31:0] rtgt);
    bit pop, mis, push;
    logic [31:0] redir;
    @(negedge clk);
    reset = rst; pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptgt;
    pred_ghr = pg; res_valid = rv; res_taken = rt; res_target = rtgt;
    #1;
    pop = rv && mq.size() > 0;
    mis = pop && (rt != mq[0].taken || (rt && rtgt != mq[0].target));
    redir = pop ? (rt ? rtgt : mq[0].pc + 32'd4) : 32'h0;
    push = pv && mq.size() < 4;
    if (!rst) begin
      check("occupancy", 32'(occupancy), 32'(mq.size()));
      check("pred_ready", 32'(pred_ready), 32'(mq.size() < 4));
      check("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
      if (m_upd_valid) begin
        check("upd_taken", 32'(upd_taken), 32'(m_upd_taken));
        check("upd_index", 32'(upd_index), 32'(m_upd_index));
      end
      check("err_underflow", 32'(err_underflow), 32'(m_err));
      check("mispredict", 32'(mispredict), 32'(mis));
      if (mis) check("redirect_pc", redirect_pc, redir);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_upd_valid = 0; m_upd_taken = 0; m_upd_index = 0; m_err = 0;
    end else begin
      m_upd_valid = pop;
      if (pop) begin
        m_upd_taken = rt;
        m_upd_index = 5'((mq[0].pc >> 2) ^ 32'(mq[0].ghr));
      end
      if (rv && mq.size() == 0) m_err = 1;
      if (mis) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{pc, pt, ptgt, pg});
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // correct taken prediction
    cycle(0, 1, 32'h100, 1, 32'h200, 5'h00, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h200);
    idle();
    check("t1_upd_index", 32'(upd_index), 32'h0);
    // direction mispredict, redirect to actual target
    cycle(0, 1, 32'h104, 0, 32'h0, 5'h03, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h300);
    idle();
    check("t2_upd_index", 32'(upd_index), 32'h2);
    // flush clears younger entries and drops the same-cycle push
    cycle(0, 1, 32'h80, 1, 32'h400, 5'h01, 0, 0, 0);
    cycle(0, 1, 32'h90, 0, 32'h0, 5'h02, 0, 0, 0);
    cycle(0, 1, 32'h94, 0, 32'h0, 5'h04, 0, 0, 0);
    cycle(0, 1, 32'ha0, 0, 32'h0, 5'h05, 1, 0, 0);
    idle();
    check("t3_occ", 32'(occupancy), 32'h0);
    // full queue, ignored push, push+pop at 3
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h1000 + 32'(i * 4), 0, 0, 5'(i), 0, 0, 0);
    check("t4_ready", 32'(pred_ready), 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h2000, 0, 0, 5'h1f, 1, 0, 0);
    idle();
    check("t4_occ", 32'(occupancy), 32'h3);
    // target-only mispredict and PC wrap on not-taken redirect
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h500, 1, 32'h600, 5'h07, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h604);
    cycle(0, 1, 32'hffff_fffc, 1, 32'h10, 5'h00, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // underflow is sticky
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h40);
    idle();
    idle();
    check("t5_err", 32'(err_underflow), 32'h1);
    // reset with entries queued and an update pending
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h700 + 32'(i * 4), 0, 0, 5'(i), 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check("t6_occ", 32'(occupancy), 32'h0);
    check("t6_err", 32'(err_underflow), 32'h0);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tg [2];
      tg[0] = 32'h200; tg[1] = 32'h300;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom & 32'hfff0_0ffc,
            1'($urandom), tg[$urandom_range(0, 1)], 5'($urandom),
            $urandom_range(0, 9) < 4, 1'($urandom), tg[$urandom_range(0, 1)]);
    end
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
